// File: rtl/circular_buffer_ctrl.sv
// Pointer/occupancy controller that runs a multi-word circular Buffer as a sliding-window FIFO.
// Pushes PAR_WRITE words per beat. Pops release min(stride, PAR_READ) words, so windows can overlap.
module circular_buffer_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int PAR_WRITE  = 1,
  parameter int PAR_READ   = 1,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [ADDR_WIDTH:0]   stride,
  output logic                  buf_wen,
  output logic [ADDR_WIDTH-1:0] buf_waddr,
  output logic [ADDR_WIDTH-1:0] buf_raddr,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty
);

  localparam int WW   = ADDR_WIDTH + 1;
  localparam int CW   = ADDR_WIDTH + 2;
  localparam bit POW2 = ((1 << ADDR_WIDTH) == DEPTH);

  localparam logic [WW-1:0]        DEPTH_W  = WW'(DEPTH);
  localparam logic [WW-1:0]        PW_W     = WW'(PAR_WRITE);
  localparam logic [WW-1:0]        PR_W     = WW'(PAR_READ);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] PR_C     = CNT_WIDTH'(PAR_READ);
  localparam logic [CNT_WIDTH-1:0] ROOM_MAX = CNT_WIDTH'(DEPTH - PAR_WRITE);

  generate
    if (DATA_WIDTH < 1 || DEPTH < 1 || PAR_WRITE < 1 || PAR_WRITE > DEPTH ||
        PAR_READ < 1 || PAR_READ > DEPTH) begin : g_bad_params
      $error("circular_buffer_ctrl: illegal DEPTH/PAR_WRITE/PAR_READ combination");
    end
  endgenerate

  // Increments never exceed DEPTH and ptr < DEPTH, so one conditional subtract wraps.
  function automatic logic [ADDR_WIDTH-1:0] ptr_add(input logic [ADDR_WIDTH-1:0] ptr,
                                                    input logic [WW-1:0]         inc);
    logic [WW-1:0] sum;
    sum = {1'b0, ptr} + inc;
    if (!POW2 && (sum >= DEPTH_W)) begin
      sum = sum - DEPTH_W;
    end
    return ADDR_WIDTH'(sum);
  endfunction

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  flush;
  logic                  push;
  logic                  pop;
  logic [WW-1:0]         stride_eff;

  assign flush = rst | clear;

  // Ready/valid look only at registered occupancy: no bypass, no fall-through.
  assign in_ready  = !flush && (count_q <= ROOM_MAX);
  assign out_valid = !flush && (count_q >= PR_C);

  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign stride_eff = (stride > PR_W) ? PR_W : stride;

  assign buf_wen   = push;
  assign buf_waddr = wptr_q;
  assign buf_raddr = rptr_q;
  assign count     = count_q;
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = ptr_add(wptr_q, PW_W);
    end
    if (pop) begin
      rptr_d = ptr_add(rptr_q, stride_eff);
    end
    count_d = CNT_WIDTH'(CW'(count_q)
                         + (push ? CW'(PW_W) : CW'(0))
                         - (pop  ? CW'(stride_eff) : CW'(0)));
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule
